// File: rtl/sdram_cmd_decode.sv
// UART command parser for the SDRAM write path: frames write/read packets and
// buffers write payload in a show-ahead FIFO drained by the sdram_write stage.
module sdram_cmd_decode #(
    parameter logic [7:0]  WR_CMD  = 8'h55,
    parameter logic [7:0]  RD_CMD  = 8'hAA,
    parameter int          WR_LEN  = 4,
    parameter int          FIFO_AW = 4,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic               sclk,
    input  logic               s_rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_flag,
    output logic               wr_trig,
    output logic               rd_trig,
    input  logic               wfifo_rd_en,
    output logic [7:0]         wfifo_rd_data,
    output logic               wfifo_empty,
    output logic               wfifo_full,
    output logic [FIFO_AW:0]   wfifo_cnt,
    output logic               pkt_err
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_V  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [3:0]         LAST_IDX = 4'(WR_LEN - 1);
    // The counter starts at 0 the cycle after a byte, so the abort decision is
    // taken one count early; pkt_err then lands TIMEOUT cycles after that byte.
    localparam logic [15:0]        TO_LAST  = TIMEOUT - 16'd2;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_WR_DATA = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [3:0]           r_byte_cnt;
    logic [15:0]          r_to_cnt;
    logic                 r_wr_trig;
    logic                 r_rd_trig;
    logic                 r_pkt_err;

    logic                 w_push_req;
    logic                 w_wr_trig_nxt;
    logic                 w_rd_trig_nxt;
    logic                 w_timeout;
    logic [3:0]           w_byte_cnt_nxt;
    logic [15:0]          w_to_cnt_nxt;

    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_cnt;
    logic                 r_empty;
    logic                 r_full;

    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [FIFO_AW:0]     w_cnt_nxt;

    // FSM state register
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_flag && (rx_data == WR_CMD)) begin
                    w_state_nxt = S_WR_DATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (rx_flag) begin
                    if (r_byte_cnt == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WR_DATA;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WR_DATA;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output logic: push request, trigger/abort decisions, counter updates
    always_comb begin
        w_push_req     = 1'b0;
        w_wr_trig_nxt  = 1'b0;
        w_rd_trig_nxt  = 1'b0;
        w_timeout      = 1'b0;
        w_byte_cnt_nxt = r_byte_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        case (r_state)
            S_IDLE: begin
                if (rx_flag && (rx_data == WR_CMD)) begin
                    w_byte_cnt_nxt = 4'd0;
                    w_to_cnt_nxt   = 16'd0;
                end else if (rx_flag && (rx_data == RD_CMD)) begin
                    w_rd_trig_nxt  = 1'b1;
                end else begin
                    w_rd_trig_nxt  = 1'b0;
                end
            end
            S_WR_DATA: begin
                if (rx_flag) begin
                    w_push_req   = 1'b1;
                    w_to_cnt_nxt = 16'd0;
                    if (r_byte_cnt == LAST_IDX) begin
                        w_wr_trig_nxt  = 1'b1;
                        w_byte_cnt_nxt = 4'd0;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 4'd1;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_to_cnt_nxt = 16'd0;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 16'd1;
                end
            end
            default: begin
                w_byte_cnt_nxt = 4'd0;
                w_to_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Framing counters and registered status pulses
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_byte_cnt <= 4'd0;
            r_to_cnt   <= 16'd0;
            r_wr_trig  <= 1'b0;
            r_rd_trig  <= 1'b0;
            r_pkt_err  <= 1'b0;
        end else begin
            r_byte_cnt <= w_byte_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_wr_trig  <= w_wr_trig_nxt;
            r_rd_trig  <= w_rd_trig_nxt;
            r_pkt_err  <= (w_push_req & r_full) | w_timeout;
        end
    end

    // Fullness is the start-of-cycle value, so a same-cycle pop never rescues a push
    assign w_wr_en = w_push_req & ~r_full;
    assign w_rd_en = wfifo_rd_en & ~r_empty;

    // FIFO occupancy next value
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_cnt_nxt = r_cnt + (FIFO_AW + 1)'(1);
            2'b01:   w_cnt_nxt = r_cnt - (FIFO_AW + 1)'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // FIFO pointers and status flags
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == DEPTH_V);
        end
    end

    // FIFO storage write port
    always_ff @(posedge sclk) begin
        if (!s_rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    assign wfifo_rd_data = r_mem[r_rd_ptr];
    assign wfifo_cnt     = r_cnt;
    assign wfifo_empty   = r_empty;
    assign wfifo_full    = r_full;
    assign wr_trig       = r_wr_trig;
    assign rd_trig       = r_rd_trig;
    assign pkt_err       = r_pkt_err;

endmodule

// File: tb/tb_sdram_cmd_decode.sv
// Scoreboard bench for sdram_cmd_decode: a packet-level model predicts pulses,
// popped bytes and FIFO occupancy; a monitor compares them against the DUT.
module tb_sdram_cmd_decode;

    localparam int TO    = 20;
    localparam int WLEN  = 4;
    localparam int DEPTH = 16;

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_flag = 1'b0;
    logic       wfifo_rd_en = 1'b0;
    logic       wr_trig, rd_trig, pkt_err;
    logic [7:0] wfifo_rd_data;
    logic       wfifo_empty, wfifo_full;
    logic [4:0] wfifo_cnt;

    sdram_cmd_decode #(
        .WR_CMD(8'h55), .RD_CMD(8'hAA), .WR_LEN(WLEN), .FIFO_AW(4), .TIMEOUT(16'(TO))
    ) dut (
        .sclk(sclk), .s_rst(s_rst), .rx_data(rx_data), .rx_flag(rx_flag),
        .wr_trig(wr_trig), .rd_trig(rd_trig), .wfifo_rd_en(wfifo_rd_en),
        .wfifo_rd_data(wfifo_rd_data), .wfifo_empty(wfifo_empty),
        .wfifo_full(wfifo_full), .wfifo_cnt(wfifo_cnt), .pkt_err(pkt_err)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    typedef struct { int c; logic [2:0] k; } ev_t;   // k = {wr_trig, rd_trig, pkt_err}
    ev_t        q_ev[$];
    logic [7:0] q_data[$];
    int         q_stat[$];

    // Reference model state: payload FIFO contents and packet framing
    logic [7:0] mq[$];
    bit         in_pkt = 1'b0;
    int         taken = 0;
    int         last_rx = 0;
    bit         mon_en = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    endtask

    task automatic step(input logic f, input logic [7:0] d, input logic re, input logic rst);
        bit full0, pop_ok, push_ok;
        @(posedge sclk);
        #1;
        rx_flag = f; rx_data = d; wfifo_rd_en = re; s_rst = rst;
        mon_en = 1'b1;
        q_stat.push_back(mq.size());
        if (rst) begin
            mq.delete(); in_pkt = 1'b0; taken = 0;
        end else begin
            full0   = (mq.size() == DEPTH);
            pop_ok  = re && (mq.size() > 0);
            push_ok = 1'b0;
            if (pop_ok) q_data.push_back(mq[0]);
            if (f) begin
                if (in_pkt) begin
                    if (full0) q_ev.push_back('{cyc + 1, 3'b001});
                    else       push_ok = 1'b1;
                    taken++;
                    last_rx = cyc;
                    if (taken == WLEN) begin
                        q_ev.push_back('{cyc + 1, 3'b100});
                        in_pkt = 1'b0;
                    end
                end else if (d == 8'h55) begin
                    in_pkt = 1'b1; taken = 0; last_rx = cyc;
                end else if (d == 8'hAA) begin
                    q_ev.push_back('{cyc + 1, 3'b010});
                end
            end else if (in_pkt && (cyc - last_rx == TO - 1)) begin
                // abort is reported TIMEOUT cycles after the last accepted byte
                q_ev.push_back('{cyc + 1, 3'b001});
                in_pkt = 1'b0;
            end
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic re = 1'b0);
        step(1'b1, d, re, 1'b0);
    endtask

    task automatic idle(input int n, input logic re = 1'b0);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, re, 1'b0);
    endtask

    // Monitor: compares occupancy every cycle, pulses when any is expected or seen,
    // and the head byte whenever the DUT accepts a pop
    always @(negedge sclk) begin
        logic [2:0] exp_p, act_p;
        if (mon_en) begin
            if (q_stat.size() > 0) begin
                int s;
                s = q_stat.pop_front();
                check("wfifo_cnt", 32'(wfifo_cnt), 32'(s));
                check("wfifo_empty", 32'(wfifo_empty), 32'(s == 0));
                check("wfifo_full", 32'(wfifo_full), 32'(s == DEPTH));
            end
            exp_p = 3'b000;
            while (q_ev.size() > 0 && q_ev[0].c <= cyc) exp_p |= q_ev.pop_front().k;
            act_p = {wr_trig, rd_trig, pkt_err};
            if (act_p !== 3'b000 || exp_p != 3'b000) check("pulses", 32'(act_p), 32'(exp_p));
            if (wfifo_rd_en === 1'b1 && wfifo_empty === 1'b0) begin
                if (q_data.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
                else check("rd_data", 32'(wfifo_rd_data), 32'(q_data.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] b;
        repeat (3) @(posedge sclk);
        #1;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);

        // basic write, then drain
        send(8'h55); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(2);
        idle(5, 1'b1);

        // read command and junk byte
        send(8'hAA); send(8'h07); idle(3);

        // overflow: five packets with no pops
        for (int p = 0; p < 5; p++) begin
            send(8'h55);
            for (int i = 0; i < WLEN; i++) send(8'(8'h20 + p * 4 + i));
        end
        idle(2);
        idle(17, 1'b1);

        // prefill 15 bytes, then stream payload with pops held high (pointer wrap)
        for (int p = 0; p < 4; p++) begin
            send(8'h55);
            for (int i = 0; i < ((p == 3) ? 3 : WLEN); i++) send(8'(8'h60 + p * 4 + i));
        end
        send(8'h6F, 1'b1);
        send(8'h55, 1'b1);
        for (int i = 0; i < WLEN; i++) send(8'(8'h70 + i), 1'b1);
        send(8'h55, 1'b1);
        for (int i = 0; i < 3; i++) send(8'(8'h74 + i), 1'b1);
        idle(20, 1'b1);

        // timeout, then a read is still recognised
        send(8'h55); send(8'hA1); send(8'hA2);
        idle(TO + 4);
        send(8'hAA); idle(2);
        idle(3, 1'b1);

        // reset mid-packet, then a clean packet
        send(8'h55); send(8'h01); send(8'h02);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);
        send(8'h55); send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        idle(2);
        idle(5, 1'b1);

        // randomized traffic with occasional stalls and resets
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                idle(TO + $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            end else if (r < 3) begin
                step(1'b0, 8'h00, 1'b0, 1'b1);
            end else begin
                r = $urandom_range(0, 9);
                b = (r < 2) ? 8'h55 : (r == 2) ? 8'hAA : 8'($urandom_range(0, 255));
                step(($urandom_range(0, 2) != 0), b, ($urandom_range(0, 3) == 0), 1'b0);
            end
        end
        idle(TO + 2);
        idle(DEPTH + 2, 1'b1);
        @(negedge sclk);
        @(negedge sclk);
        check("leftover_expectations", 32'(q_ev.size() + q_data.size() + q_stat.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
